loop_sequencer: RTL and testbench

Sample-rate scheduler for the discrete integrator/PI datapath (error sum, ×7 gain, accumulator register with EN).
- Each sample period: requests one ADC conversion, latches the measurement as yk, waits for the combinational datapath to settle, then pulses the accumulator EN for exactly one cycle.
- Afterwards it hands the new ik to the DAC over a load/busy handshake.
- Sits between the ADC/DAC interface logic and the Integrador datapath, one instance per control loop.

---
 rtl/loop_sequencer_pkg.sv | 22 ++
 rtl/loop_sequencer_period_timer.sv | 46 ++++
 rtl/loop_sequencer.sv | 146 ++++++++++++++
 tb/tb_loop_sequencer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_sequencer_pkg.sv
// Shared FSM encoding, period limits and default datapath constants for loop_sequencer.
package loop_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_CAPT    = 3'd4,
    ST_WAITDAC = 3'd5
  } seq_state_t;

  localparam int MIN_PERIOD = 8;
  localparam int DEF_SIZE   = 19;
  localparam logic signed [DEF_SIZE-1:0] DEF_IK_MAX = 19'sd131071;

  // Requested periods shorter than MIN_PERIOD are stretched to MIN_PERIOD.
  function automatic int effective_period(input int cfg);
    return (cfg < MIN_PERIOD) ? MIN_PERIOD : cfg;
  endfunction

endpackage

// File: rtl/loop_sequencer_period_timer.sv
// Reloadable sample-period down-counter; emits a one-cycle tick every max(period_cfg,8) cycles while run=1.
module period_timer
  import loop_sequencer_pkg::*;
#(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [PW-1:0] period_cfg,
  output logic          tick
);

  logic [PW-1:0] count;
  logic          armed;
  logic [PW-1:0] reload;

  // period_cfg only matters at the moments reload is consumed
  always_comb begin
    reload = PW'(effective_period(int'(period_cfg)) - 1);
  end

  // Counter: cleared while stopped, loaded on the first running cycle, reloaded at each tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      armed <= 1'b0;
      tick  <= 1'b0;
    end else if (!run) begin
      count <= '0;
      armed <= 1'b0;
      tick  <= 1'b0;
    end else if (!armed) begin
      count <= reload;
      armed <= 1'b1;
      tick  <= 1'b0;
    end else if (count == '0) begin
      count <= reload;
      tick  <= 1'b1;
    end else begin
      count <= count - PW'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/loop_sequencer.sv
// Sample-rate scheduler for the integrator/PI datapath: ADC request, settle, EN pulse, DAC hand-off.
// Optional anti-windup clamp on int_en is enabled by defining INTEG_CLAMP_EN.
module loop_sequencer
  import loop_sequencer_pkg::*;
#(
  parameter int SIZE   = DEF_SIZE,
  parameter int PW     = 16,
  parameter int SETTLE = 2,
  parameter int ADC_TO = 255,
  parameter logic signed [SIZE-1:0] IK_MAX = SIZE'(DEF_IK_MAX)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [PW-1:0]          period_cfg,
  output logic                   adc_req,
  input  logic                   adc_ack,
  input  logic signed [SIZE-1:0] adc_data,
  output logic signed [SIZE-1:0] yk,
  output logic                   int_en,
  input  logic signed [SIZE-1:0] ik_in,
  input  logic signed [SIZE-1:0] ek_in,
  output logic                   dac_load,
  input  logic                   dac_busy,
  output logic signed [SIZE-1:0] dac_data,
  output logic                   overrun,
  output logic                   adc_timeout,
  output logic                   windup
);

  localparam int TW = (ADC_TO > 1) ? $clog2(ADC_TO) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  seq_state_t    state;
  logic [TW-1:0] wait_cnt;
  logic [SW-1:0] settle_cnt;
  logic          tick;
  logic          clamp;

  period_timer #(.PW(PW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .period_cfg(period_cfg),
    .tick      (tick)
  );

`ifdef INTEG_CLAMP_EN
  localparam logic signed [SIZE-1:0] ZERO = '0;

  function automatic logic clamp_hit(input logic signed [SIZE-1:0] ik,
                                     input logic signed [SIZE-1:0] ek);
    return ((ik >= IK_MAX) && (ek > ZERO)) || ((ik <= -IK_MAX) && (ek < ZERO));
  endfunction

  assign clamp = clamp_hit(ik_in, ek_in);
`else
  logic unused_clamp_inputs;
  assign unused_clamp_inputs = ^{ek_in, IK_MAX};
  assign clamp = 1'b0;
`endif

  // Sequencer FSM with registered strobes and sticky status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      settle_cnt  <= '0;
      adc_req     <= 1'b0;
      int_en      <= 1'b0;
      dac_load    <= 1'b0;
      yk          <= '0;
      dac_data    <= '0;
      overrun     <= 1'b0;
      adc_timeout <= 1'b0;
      windup      <= 1'b0;
    end else if (!run) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      settle_cnt <= '0;
      adc_req    <= 1'b0;
      int_en     <= 1'b0;
      dac_load   <= 1'b0;
    end else begin
      int_en   <= 1'b0;
      dac_load <= 1'b0;
      if (tick && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state    <= ST_REQ;
            adc_req  <= 1'b1;
            wait_cnt <= '0;
          end
        end
        ST_REQ: begin
          // an ack arriving in the expiry cycle still counts
          if (adc_ack) begin
            yk         <= adc_data;
            adc_req    <= 1'b0;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end else if (wait_cnt == TW'(ADC_TO - 1)) begin
            adc_timeout <= 1'b1;
            adc_req     <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            state <= ST_UPDATE;
            if (clamp) begin
              windup <= 1'b1;
            end else begin
              int_en <= 1'b1;
            end
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        ST_UPDATE: begin
          state <= ST_CAPT;
        end
        ST_CAPT: begin
          dac_data <= ik_in;
          state    <= ST_WAITDAC;
        end
        ST_WAITDAC: begin
          if (!dac_busy) begin
            dac_load <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          adc_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loop_sequencer.sv
// Self-checking bench for loop_sequencer: ADC/DAC/datapath responders plus a timestamp-based reference model.
module tb_loop_sequencer;

  localparam int SIZE   = 19;
  localparam int PW     = 16;
  localparam int SETTLE = 2;
  localparam int ADC_TO = 255;
`ifdef INTEG_CLAMP_EN
  localparam int CLAMP_INT_EN = 0;
  localparam logic CLAMP_WINDUP = 1'b1;
`else
  localparam int CLAMP_INT_EN = 1;
  localparam logic CLAMP_WINDUP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
  logic [PW-1:0] period_cfg = 16'd20;
  logic adc_req, int_en, dac_load, overrun, adc_timeout, windup;
  logic adc_ack = 1'b0;
  logic dac_busy = 1'b0;
  logic signed [SIZE-1:0] adc_data = '0;
  logic signed [SIZE-1:0] ik_in = '0;
  logic signed [SIZE-1:0] ek_in = '0;
  logic signed [SIZE-1:0] yk, dac_data;

  int checks = 0;
  int errors = 0;

  bit adc_en = 1'b1;
  int ack_delay = 3;
  bit data_rand = 1'b0;
  logic signed [SIZE-1:0] data_fixed = 19'sd100;
  bit ik_rand = 1'b1;
  bit busy_rand = 1'b0;
  bit stray = 1'b0;

  logic exp_adc_req = 1'b0, exp_int_en = 1'b0, exp_dac_load = 1'b0;
  logic exp_overrun = 1'b0, exp_adc_timeout = 1'b0, exp_windup = 1'b0;
  logic signed [SIZE-1:0] exp_yk = '0, exp_dac_data = '0;

  logic [43:0] obs, expv;
  assign obs  = {adc_req, int_en, dac_load, overrun, adc_timeout, windup, yk, dac_data};
  assign expv = {exp_adc_req, exp_int_en, exp_dac_load, exp_overrun, exp_adc_timeout,
                 exp_windup, exp_yk, exp_dac_data};

  always #5 clk = ~clk;

  loop_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .period_cfg(period_cfg),
    .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data), .yk(yk),
    .int_en(int_en), .ik_in(ik_in), .ek_in(ek_in), .dac_load(dac_load),
    .dac_busy(dac_busy), .dac_data(dac_data), .overrun(overrun),
    .adc_timeout(adc_timeout), .windup(windup)
  );

  // ADC answers ack_delay cycles into a request; datapath and DAC busy are randomised on demand.
  initial begin : responder
    int req_cycles;
    logic [31:0] r;
    req_cycles = 0;
    forever begin
      @(negedge clk);
      adc_ack = 1'b0;
      if (adc_req) req_cycles++; else req_cycles = 0;
      if (adc_en && adc_req && req_cycles == ack_delay) begin
        r = $urandom;
        adc_ack = 1'b1;
        adc_data = data_rand ? r[SIZE-1:0] : data_fixed;
      end else if (stray) begin
        r = $urandom;
        adc_ack = 1'b1;
        adc_data = r[SIZE-1:0];
        stray = 1'b0;
      end
      if (ik_rand) begin
        r = $urandom; ik_in = r[SIZE-1:0];
        r = $urandom; ek_in = r[SIZE-1:0];
      end
      if (busy_rand) begin
        r = $urandom; dac_busy = r[0] & r[1];
      end
    end
  end

  // Reference model: ticks from arithmetic on edge numbers, sequence phases from ack timestamps.
  initial begin : model
    int n, next_tick, start_edge, ack_edge, d, p;
    bit running, tick_q, seq, was, tick_in;
`ifdef INTEG_CLAMP_EN
    int ik, ek;
`endif
    n = 0; next_tick = 0; start_edge = 0; ack_edge = -1;
    running = 1'b0; tick_q = 1'b0; seq = 1'b0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        running = 1'b0; tick_q = 1'b0; seq = 1'b0; ack_edge = -1;
        exp_adc_req = 1'b0; exp_int_en = 1'b0; exp_dac_load = 1'b0;
        exp_overrun = 1'b0; exp_adc_timeout = 1'b0; exp_windup = 1'b0;
        exp_yk = '0; exp_dac_data = '0;
      end else begin
        tick_in = tick_q; was = seq; tick_q = 1'b0;
        exp_int_en = 1'b0; exp_dac_load = 1'b0;
        p = (int'(period_cfg) < 8) ? 8 : int'(period_cfg);
        if (!run) begin
          running = 1'b0; seq = 1'b0;
        end else begin
          if (!running) begin
            running = 1'b1; next_tick = n + p;
          end else if (n == next_tick) begin
            tick_q = 1'b1; next_tick = n + p;
          end
          if (was) begin
            if (ack_edge < 0) begin
              if (adc_ack) begin
                ack_edge = n; exp_yk = adc_data;
              end else if (n - start_edge == ADC_TO) begin
                exp_adc_timeout = 1'b1; seq = 1'b0;
              end
            end else begin
              d = n - ack_edge;
              if (d == SETTLE) begin
`ifdef INTEG_CLAMP_EN
                ik = int'(ik_in); ek = int'(ek_in);
                if ((ik >= 131071 && ek > 0) || (ik <= -131071 && ek < 0)) exp_windup = 1'b1;
                else exp_int_en = 1'b1;
`else
                exp_int_en = 1'b1;
`endif
              end else if (d == SETTLE + 2) begin
                exp_dac_data = ik_in;
              end else if (d >= SETTLE + 3 && !dac_busy) begin
                exp_dac_load = 1'b1; seq = 1'b0;
              end
            end
          end
          if (tick_in) begin
            if (was) exp_overrun = 1'b1;
            else begin seq = 1'b1; start_edge = n; ack_edge = -1; end
          end
        end
        exp_adc_req = seq && (ack_edge < 0);
        n++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0; run = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== 44'd0) begin
      errors++;
      $display("FAIL reset_state: got %h, expected 0", obs);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n_int, first_int;
    n_int = 0; first_int = -1;
    data_rand = 1'b0; data_fixed = 19'sd100; ack_delay = 3; period_cfg = 16'd20;
    run = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL basic cycle %0d: got %h, expected %h", i, obs, expv);
      end
      if (int_en === 1'b1) begin
        n_int++;
        if (first_int < 0) first_int = i;
      end
    end
    checks++;
    if (yk !== 19'sd100) begin errors++; $display("FAIL basic_yk: got %0d, expected 100", yk); end
    checks++;
    if (n_int != 3) begin errors++; $display("FAIL basic_int_count: got %0d, expected 3", n_int); end
    checks++;
    if (first_int != 26) begin errors++; $display("FAIL basic_int_latency: got %0d, expected 26", first_int); end
  endtask

  task automatic test_timeout();
    int req_cyc, n_int;
    req_cyc = 0; n_int = 0;
    run = 1'b0; @(negedge clk);
    adc_en = 1'b0; period_cfg = 16'd400; run = 1'b1;
    for (int i = 0; i < 670; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL timeout cycle %0d: got %h, expected %h", i, obs, expv);
      end
      if (adc_req === 1'b1) req_cyc++;
      if (int_en === 1'b1) n_int++;
    end
    checks++;
    if (req_cyc != 255) begin errors++; $display("FAIL timeout_req_len: got %0d, expected 255", req_cyc); end
    checks++;
    if (adc_timeout !== 1'b1 || n_int != 0 || yk !== 19'sd100) begin
      errors++;
      $display("FAIL timeout_flags: got to=%b int=%0d yk=%0d, expected to=1 int=0 yk=100", adc_timeout, n_int, yk);
    end
    // ack landing in the very cycle the wait expires must win
    adc_en = 1'b1; ack_delay = 255; data_rand = 1'b1; n_int = 0;
    for (int i = 0; i < 420; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL ack_at_limit cycle %0d: got %h, expected %h", i, obs, expv);
      end
      if (int_en === 1'b1) n_int++;
    end
    checks++;
    if (n_int != 1) begin errors++; $display("FAIL ack_at_limit_int: got %0d, expected 1", n_int); end
  endtask

  task automatic test_overrun();
    int n_int, n_load;
    n_int = 0; n_load = 0;
    run = 1'b0; @(negedge clk);
    period_cfg = 16'd8; ack_delay = 2; dac_busy = 1'b1; run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL overrun_busy cycle %0d: got %h, expected %h", i, obs, expv);
      end
      if (int_en === 1'b1) n_int++;
      if (dac_load === 1'b1) n_load++;
    end
    dac_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL overrun_release cycle %0d: got %h, expected %h", i, obs, expv);
      end
      if (i < 5 && dac_load === 1'b1) n_load++;
    end
    checks++;
    if (overrun !== 1'b1 || n_int != 1 || n_load != 1) begin
      errors++;
      $display("FAIL overrun_summary: got ovr=%b int=%0d load=%0d, expected 1 1 1", overrun, n_int, n_load);
    end
  endtask

  task automatic test_run_drop();
    int n_int;
    bit prev_req, found;
    n_int = 0; prev_req = 1'b0; found = 1'b0;
    run = 1'b0; @(negedge clk);
    period_cfg = 16'd20; ack_delay = 3; run = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL run_drop_pre cycle %0d: got %h, expected %h", i, obs, expv);
      end
      if (prev_req && !exp_adc_req) found = 1'b1;
      prev_req = exp_adc_req;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL run_drop_wait: got no ack within 100 cycles, expected one"); end
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv || int_en !== 1'b0) begin
        errors++;
        $display("FAIL run_drop_idle cycle %0d: got %h, expected %h", i, obs, expv);
      end
    end
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL run_restore cycle %0d: got %h, expected %h", i, obs, expv);
      end
      if (int_en === 1'b1) n_int++;
    end
    checks++;
    if (n_int != 1) begin errors++; $display("FAIL run_restore_int: got %0d, expected 1", n_int); end
  endtask

  task automatic test_clamp();
    int n_int, n_load;
    ik_rand = 1'b0; ik_in = 19'sd131071; ek_in = 19'sd5;
    period_cfg = 16'd20; ack_delay = 3;
    for (int pass = 0; pass < 2; pass++) begin
      n_int = 0; n_load = 0;
      run = 1'b0; @(negedge clk);
      run = 1'b1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL clamp pass %0d cycle %0d: got %h, expected %h", pass, i, obs, expv);
        end
        if (int_en === 1'b1) n_int++;
        if (dac_load === 1'b1) n_load++;
      end
      checks++;
      if (n_int != (pass == 0 ? CLAMP_INT_EN : 1) || n_load != 1 || windup !== CLAMP_WINDUP) begin
        errors++;
        $display("FAIL clamp_summary pass %0d: got int=%0d load=%0d wu=%b, expected int=%0d load=1 wu=%b",
                 pass, n_int, n_load, windup, (pass == 0 ? CLAMP_INT_EN : 1), CLAMP_WINDUP);
      end
      ek_in = -19'sd5;
    end
    ik_rand = 1'b1;
  endtask

  task automatic test_random();
    int len;
    data_rand = 1'b1; ik_rand = 1'b1; busy_rand = 1'b1;
    for (int ep = 0; ep < 30; ep++) begin
      period_cfg = 16'($urandom_range(0, 30));
      ack_delay = ($urandom_range(0, 9) == 0) ? 300 : int'($urandom_range(1, 6));
      run = 1'b1;
      len = int'($urandom_range(20, 120));
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL random ep %0d cycle %0d: got %h, expected %h", ep, i, obs, expv);
        end
        if ($urandom_range(0, 19) == 0) stray = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        run = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("FAIL random_stop ep %0d: got %h, expected %h", ep, obs, expv);
        end
      end
    end
    busy_rand = 1'b0; dac_busy = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found;
    found = 1'b0;
    run = 1'b0; @(negedge clk);
    period_cfg = 16'd20; ack_delay = 10; data_rand = 1'b1; run = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL areset_pre cycle %0d: got %h, expected %h", i, obs, expv);
      end
      if (exp_adc_req) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL areset_wait: got no request within 60 cycles, expected one"); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs !== 44'd0) begin
      errors++;
      $display("FAIL areset_immediate: got %h, expected 0", obs);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL areset_post cycle %0d: got %h, expected %h", i, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_overrun();
    test_run_drop();
    test_clamp();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
